// File: rtl/core_rbm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_rbm_ctrl
// Purpose  : Bus-side load/store controller placed after the memory access
//            unit. Takes one aligned access per transaction, runs it over a
//            req/gnt/rvalid bus handshake, stalls the pipeline while it is
//            outstanding and returns the raw 32-bit read word. Misaligned or
//            malformed sizes and bus timeouts complete with an error pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   rbm_addr_i [31:0]     byte address of the access
//   rbm_data_i [31:0]     store data, already lane-aligned
//   rbm_size_i [2:0]      one-hot {word, half, byte}
//   rbm_we_i / rbm_rd_i   store / load request (store wins if both)
//   rbm_data_o [31:0]     raw read word, held until the next load completes
//   rbm_ack_o / rbm_err_o one-cycle completion / error pulse
//   stall_o               hold the pipeline
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o   bus request side
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i          bus response side
// ============================================================================
module core_rbm_ctrl #(
  parameter int unsigned TIMEOUT = 255  // 2..255, cycles from request to abort
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] rbm_addr_i,
  input  logic [31:0] rbm_data_i,
  input  logic [2:0]  rbm_size_i,
  input  logic        rbm_we_i,
  input  logic        rbm_rd_i,
  output logic [31:0] rbm_data_o,
  output logic        rbm_ack_o,
  output logic        rbm_err_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Abort fires on the cycle whose counter value is TIMEOUT-1, so the
  // counter has reached TIMEOUT when the DONE state is entered.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q,    be_d;
  logic        we_q,    we_d;
  logic        err_q,   err_d;
  logic [7:0]  cnt_q,   cnt_d;

  logic        req_w;
  logic        legal_w;
  logic [3:0]  be_w;
  logic        timeout_w;

  assign req_w     = rbm_we_i | rbm_rd_i;
  assign timeout_w = (cnt_q >= TO_LAST);

  // Legality and byte enables decoded straight from the incoming request.
  always_comb begin
    legal_w = 1'b0;
    be_w    = 4'b1111;
    case (rbm_size_i)
      3'b001: begin
        legal_w = 1'b1;
        be_w    = 4'b0001 << rbm_addr_i[1:0];
      end
      3'b010: begin
        legal_w = ~rbm_addr_i[0];
        be_w    = rbm_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      3'b100: begin
        legal_w = (rbm_addr_i[1:0] == 2'b00);
        be_w    = 4'b1111;
      end
      default: begin
        legal_w = 1'b0;
        be_w    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_w) begin
          addr_d  = {rbm_addr_i[31:2], 2'b00};
          wdata_d = rbm_data_i;
          be_d    = be_w;
          we_d    = rbm_we_i;
          cnt_d   = 8'd0;
          if (legal_w) begin
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            // Illegal access never reaches the bus; a failed load reads 0.
            err_d   = 1'b1;
            state_d = DONE;
            if (!rbm_we_i) rdata_d = 32'd0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_gnt_i) begin
          state_d = WAIT;
        end else if (timeout_w) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = 32'd0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_rvalid_i) begin
          err_d   = bus_err_i;
          state_d = DONE;
          if (!we_q) rdata_d = bus_err_i ? 32'd0 : bus_rdata_i;
        end else if (timeout_w) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = 32'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from registers (reset clears them asynchronously),
  // except stall, which must also cover the accept cycle in IDLE.
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign rbm_data_o  = rdata_q;
  assign rbm_ack_o   = (state_q == DONE);
  assign rbm_err_o   = (state_q == DONE) & err_q;
  assign stall_o     = ((state_q == IDLE) & req_w) | (state_q == REQ) | (state_q == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_core_rbm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_rbm_ctrl
// Purpose  : Self-checking bench for core_rbm_ctrl. Expected timing and data
//            come from a transaction-level model (legality, byte lanes,
//            grant/response delays and timeout arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_rbm_ctrl;

  localparam int TO  = 16;
  localparam int TO4 = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] rbm_addr_i = '0;
  logic [31:0] rbm_data_i = '0;
  logic [2:0]  rbm_size_i = '0;
  logic        rbm_we_i = 1'b0;
  logic        rbm_rd_i = 1'b0;
  logic        t_rd_i = 1'b0;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_i = 1'b0;

  logic [31:0] rbm_data_o, bus_addr_o, bus_wdata_o;
  logic        rbm_ack_o, rbm_err_o, stall_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;

  logic [31:0] t_data_o, t_addr_o, t_wdata_o;
  logic        t_ack_o, t_err_o, t_stall_o, t_req_o, t_we_o;
  logic [3:0]  t_be_o;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_data = '0;

  always #5 clk_i = ~clk_i;

  core_rbm_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rbm_addr_i(rbm_addr_i), .rbm_data_i(rbm_data_i), .rbm_size_i(rbm_size_i),
    .rbm_we_i(rbm_we_i), .rbm_rd_i(rbm_rd_i),
    .rbm_data_o(rbm_data_o), .rbm_ack_o(rbm_ack_o), .rbm_err_o(rbm_err_o),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  // Short-timeout instance, only requested during the timeout scenario.
  core_rbm_ctrl #(.TIMEOUT(TO4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .rbm_addr_i(rbm_addr_i), .rbm_data_i(rbm_data_i), .rbm_size_i(rbm_size_i),
    .rbm_we_i(1'b0), .rbm_rd_i(t_rd_i),
    .rbm_data_o(t_data_o), .rbm_ack_o(t_ack_o), .rbm_err_o(t_err_o),
    .stall_o(t_stall_o), .bus_req_o(t_req_o), .bus_we_o(t_we_o),
    .bus_addr_o(t_addr_o), .bus_be_o(t_be_o), .bus_wdata_o(t_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, act, exp);
    end
  endtask

  // Idle cycles with no request: controller must stay quiet.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      rbm_we_i = 1'b0; rbm_rd_i = 1'b0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
      #1;
      check("idle_ack", rbm_ack_o, 1'b0);
      check("idle_stall", stall_o, 1'b0);
    end
  endtask

  // One transaction. g = no-grant REQ cycles before the grant cycle,
  // r = idle WAIT cycles before rvalid. junk adds ignored rvalid pulses in REQ
  // and scrambles request inputs once accepted.
  task automatic run_txn(input logic we, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] size,
                         input int g, input int r, input logic berr,
                         input logic [31:0] rdata, input bit junk);
    int n, ack_c, req_end, jt;
    bit legal, gnt_ok, rv_ok, err;
    logic [3:0]  be;
    logic [31:0] new_data;
    n = (size == 3'b001) ? 1 : (size == 3'b010) ? 2 : (size == 3'b100) ? 4 : 0;
    legal = (n != 0) && ((addr % n) == 0);
    for (int i = 0; i < 4; i++)
      be[i] = (i >= int'(addr[1:0])) && (i < int'(addr[1:0]) + n);
    gnt_ok = 0; rv_ok = 0; req_end = 0;
    if (!legal) begin
      ack_c = 1; err = 1;
    end else if (g >= TO) begin
      ack_c = 1 + TO; err = 1; req_end = TO;
    end else begin
      gnt_ok = 1; req_end = 1 + g;
      jt = TO - 2 - g;
      if (jt < 0) jt = 0;
      if (r <= jt) begin ack_c = 3 + g + r; err = berr; rv_ok = 1; end
      else begin ack_c = 3 + g + jt; err = 1; end
    end
    if (we) new_data = exp_data;
    else    new_data = err ? 32'd0 : rdata;

    for (int c = 0; c <= ack_c; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        rbm_we_i = we; rbm_rd_i = rd; rbm_addr_i = addr;
        rbm_data_i = data; rbm_size_i = size;
      end else if (junk) begin
        rbm_addr_i = $urandom; rbm_data_i = $urandom; rbm_size_i = 3'($urandom);
      end
      bus_gnt_i    = gnt_ok && (c == 1 + g);
      bus_rvalid_i = 1'b0;
      bus_err_i    = 1'($urandom);
      bus_rdata_i  = $urandom;
      if (rv_ok && c == 2 + g + r) begin
        bus_rvalid_i = 1'b1; bus_err_i = berr; bus_rdata_i = rdata;
      end else if (junk && legal && c >= 1 && c <= req_end) begin
        bus_rvalid_i = 1'($urandom);
      end
      #1;
      check("stall", stall_o, c < ack_c);
      check("ack", rbm_ack_o, c == ack_c);
      check("err", rbm_err_o, (c == ack_c) && err);
      check("bus_req", bus_req_o, legal && c >= 1 && c <= req_end);
      if (legal && c >= 1 && c <= req_end) begin
        check("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
        check("bus_be", bus_be_o, be);
        check("bus_we", bus_we_o, we);
        if (we) check("bus_wdata", bus_wdata_o, data);
      end
      check("rbm_data", rbm_data_o, (c == ack_c) ? new_data : exp_data);
    end
    exp_data = new_data;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_data", rbm_data_o, 32'd0);
    check("rst_ack", rbm_ack_o, 1'b0);
    check("rst_err", rbm_err_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req", bus_req_o, 1'b0);
    check("rst_we", bus_we_o, 1'b0);
    check("rst_addr", bus_addr_o, 32'd0);
    check("rst_be", bus_be_o, 4'd0);
    check("rst_wdata", bus_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_cycles(2);

    // Directed cases
    run_txn(1'b0, 1'b1, 32'h100, 32'h0, 3'b100, 0, 0, 1'b0, 32'hDEADBEEF, 0);
    run_txn(1'b1, 1'b0, 32'h203, 32'hAB000000, 3'b001, 1, 0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 32'h101, 32'h0, 3'b010, 0, 0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 32'h104, 32'h0, 3'b100, 0, 1, 1'b0, 32'h12345678, 0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 3'b011, 0, 0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 32'h108, 32'h0, 3'b100, 0, 0, 1'b0, 32'hCAFEF00D, 0);
    run_txn(1'b0, 1'b1, 32'h10C, 32'h0, 3'b100, 5, 2, 1'b1, 32'h55AA55AA, 0);
    run_txn(1'b1, 1'b1, 32'h302, 32'h12340000, 3'b010, 0, 0, 1'b0, 32'h0, 1);
    run_txn(1'b0, 1'b1, 32'h400, 32'h0, 3'b001, 20, 0, 1'b0, 32'h0, 1);
    run_txn(1'b0, 1'b1, 32'h404, 32'h0, 3'b100, 2, 20, 1'b0, 32'h0, 0);
    idle_cycles(1);

    // Short-timeout instance: never granted, aborts at counter 4, and a
    // held request is taken again in the IDLE cycle after DONE.
    @(negedge clk_i);
    rbm_addr_i = 32'h500; rbm_size_i = 3'b100; t_rd_i = 1'b1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    for (int c = 0; c <= 2 * (TO4 + 1) + 1; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      check("t_ack", t_ack_o, c == TO4 + 1 || c == 2 * (TO4 + 1) + 1);
      check("t_err", t_err_o, c == TO4 + 1 || c == 2 * (TO4 + 1) + 1);
      check("t_req", t_req_o, (c >= 1 && c <= TO4) || (c >= TO4 + 3 && c <= 2 * TO4 + 2));
      check("t_stall", t_stall_o, c != TO4 + 1 && c != 2 * (TO4 + 1) + 1);
      check("t_data", t_data_o, 32'd0);
    end
    @(negedge clk_i);
    t_rd_i = 1'b0;
    idle_cycles(1);

    // Reset during WAIT
    @(negedge clk_i);
    rbm_rd_i = 1'b1; rbm_addr_i = 32'h600; rbm_size_i = 3'b100;
    @(negedge clk_i);
    bus_gnt_i = 1'b1;
    #1 check("mid_req", bus_req_o, 1'b1);
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    #2;
    rst_i = 1'b1; rbm_rd_i = 1'b0;
    #1;
    exp_data = 32'd0;
    check("arst_req", bus_req_o, 1'b0);
    check("arst_stall", stall_o, 1'b0);
    check("arst_ack", rbm_ack_o, 1'b0);
    check("arst_addr", bus_addr_o, 32'd0);
    check("arst_be", bus_be_o, 4'd0);
    check("arst_data", rbm_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_cycles(3);
    run_txn(1'b0, 1'b1, 32'h700, 32'h0, 3'b100, 0, 0, 1'b0, 32'h0BADF00D, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  rw;
      logic [2:0]  sz;
      logic [31:0] ad;
      rw = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 4))
        0: sz = 3'b001;
        1: sz = 3'b010;
        2: sz = 3'b100;
        default: sz = 3'($urandom);
      endcase
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 3'b100) ad[1:0] = 2'b00;
        if (sz == 3'b010) ad[0] = 1'b0;
      end
      run_txn(rw[0], rw[1], ad, $urandom, sz,
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4),
              $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom,
              bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
